tcdm_bank_responder: RTL and testbench

// Slave-side end of the TCDM interconnect. Accepts tcdm_slave_req_t from the tile crossbar and drives one
// 1-cycle-latency SRAM bank. Executes loads, stores, LR/SC and AMOs as read-modify-write on that bank.

---
 rtl/tcdm_bank_responder_pkg.sv | 93 +++++++++
 rtl/tcdm_resp_fifo.sv | 56 +++++
 rtl/tcdm_bank_responder.sv | 168 ++++++++++++++++
 tb/tb_tcdm_bank_responder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_bank_responder_pkg.sv
// Shared TCDM bank-side types, AMO encoding and AMO arithmetic.
package tcdm_bank_responder_pkg;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NumBanksPerTile     = 16;
  localparam int unsigned BankIdxWidthDefault = idx_width(NumBanksPerTile);
  localparam int unsigned TCDMAddrMemWidth    = 8;
  localparam int unsigned TgtAddrWidth        = BankIdxWidthDefault + TCDMAddrMemWidth;
  localparam int unsigned DataWidth           = 32;
  localparam int unsigned BeWidth             = DataWidth / 8;
  localparam int unsigned IniAddrWidth        = 4;
  localparam int unsigned MetaIdWidth         = 8;
  localparam int unsigned CoreIdWidth         = 3;
  localparam int unsigned AmoWidth            = 4;

  typedef logic [DataWidth-1:0]        data_t;
  typedef logic [BeWidth-1:0]          strb_t;
  typedef logic [TCDMAddrMemWidth-1:0] bank_addr_t;
  typedef logic [TgtAddrWidth-1:0]     tgt_addr_t;
  typedef logic [IniAddrWidth-1:0]     ini_addr_t;
  typedef logic [MetaIdWidth-1:0]      meta_id_t;
  typedef logic [CoreIdWidth-1:0]      core_id_t;
  typedef logic [AmoWidth-1:0]         amo_t;

  localparam amo_t AmoNone = 4'h0;
  localparam amo_t AmoSwap = 4'h1;
  localparam amo_t AmoAdd  = 4'h2;
  localparam amo_t AmoAnd  = 4'h3;
  localparam amo_t AmoOr   = 4'h4;
  localparam amo_t AmoXor  = 4'h5;
  localparam amo_t AmoMax  = 4'h6;
  localparam amo_t AmoMaxu = 4'h7;
  localparam amo_t AmoMin  = 4'h8;
  localparam amo_t AmoMinu = 4'h9;
  localparam amo_t AmoLR   = 4'hA;
  localparam amo_t AmoSC   = 4'hB;

  typedef struct packed {
    meta_id_t meta_id;
    core_id_t core_id;
    amo_t     amo;
    data_t    data;
  } tcdm_payload_t;

  typedef struct packed {
    tcdm_payload_t wdata;
    logic          wen;
    strb_t         be;
    tgt_addr_t     tgt_addr;
    ini_addr_t     ini_addr;
  } tcdm_slave_req_t;

  typedef struct packed {
    tcdm_payload_t rdata;
    ini_addr_t     ini_addr;
  } tcdm_slave_resp_t;

  typedef struct packed {
    logic       valid;
    bank_addr_t addr;
    ini_addr_t  ini_addr;
    core_id_t   core_id;
  } tcdm_reservation_t;

  typedef enum logic {
    StIdle,
    StAmoWb
  } tcdm_bank_state_e;

  // New memory word for a read-modify-write AMO; non-RMW codes leave it unchanged.
  function automatic data_t amo_alu(amo_t op, data_t old, data_t operand);
    data_t res;
    res = old;
    case (op)
      AmoNone: res = old;
      AmoSwap: res = operand;
      AmoAdd:  res = old + operand;
      AmoAnd:  res = old & operand;
      AmoOr:   res = old | operand;
      AmoXor:  res = old ^ operand;
      AmoMax:  res = ($signed(old) > $signed(operand)) ? old : operand;
      AmoMaxu: res = (old > operand) ? old : operand;
      AmoMin:  res = ($signed(old) < $signed(operand)) ? old : operand;
      AmoMinu: res = (old < operand) ? old : operand;
      default: res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tcdm_resp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible the same cycle.
module tcdm_resp_fifo
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  tcdm_slave_resp_t               i_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output tcdm_slave_resp_t               o_data,
  output logic [$clog2(Depth+1)-1:0]     o_count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  tcdm_slave_resp_t r_mem [Depth];
  logic [PtrW-1:0]  r_wr;
  logic [PtrW-1:0]  r_rd;
  logic [CntW-1:0]  r_count;
  logic             w_empty;
  logic             w_pop;
  logic             w_store;
  logic             w_drain;

  assign w_empty = (r_count == '0);
  assign o_valid = i_push | ~w_empty;
  assign o_data  = w_empty ? i_data : r_mem[r_rd];
  assign w_pop   = o_valid & i_ready;
  // An entry consumed in its push cycle bypasses the storage entirely.
  assign w_store = i_push & ~(w_empty & i_ready);
  assign w_drain = w_pop & ~w_empty;
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_wr <= (r_wr == PtrW'(Depth - 1)) ? '0 : r_wr + PtrW'(1);
      if (w_drain) r_rd <= (r_rd == PtrW'(Depth - 1)) ? '0 : r_rd + PtrW'(1);
      r_count <= r_count + CntW'(w_store) - CntW'(w_drain);
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk) begin
    if (w_store) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Slave-side TCDM bank adapter: loads, stores, LR/SC and AMOs on a 1-cycle SRAM bank.
module tcdm_bank_responder
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned RespDepth    = 2,
  parameter int unsigned BankIdxWidth = BankIdxWidthDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  tcdm_slave_req_t  req_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output tcdm_slave_resp_t resp_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output bank_addr_t       mem_addr_o,
  output data_t            mem_wdata_o,
  output strb_t            mem_be_o,
  input  data_t            mem_rdata_i
);

  localparam int unsigned CntW = $clog2(RespDepth + 1);

  tcdm_bank_state_e  r_state;
  tcdm_bank_state_e  w_state_next;
  tcdm_reservation_t r_res;
  logic              r_inflight;
  logic              r_pend_sc;
  logic              r_sc_fail;
  meta_id_t          r_meta;
  core_id_t          r_core;
  ini_addr_t         r_ini;
  amo_t              r_amo;
  data_t             r_operand;
  bank_addr_t        r_wb_addr;

  amo_t              w_amo;
  bank_addr_t        w_req_addr;
  logic              w_is_rmw;
  logic              w_is_lr;
  logic              w_is_sc;
  logic              w_is_store;
  logic              w_sc_ok;
  logic              w_accept;
  logic              w_push;
  logic              w_wb_kill;
  logic [CntW-1:0]   w_fifo_count;
  logic [CntW:0]     w_used;
  tcdm_slave_resp_t  w_push_data;
  logic              w_unused_bank_idx;

  // Request decode; unknown AMO codes fall back to plain load/store.
  assign w_amo             = req_i.wdata.amo;
  assign w_req_addr        = req_i.tgt_addr[BankIdxWidth +: TCDMAddrMemWidth];
  assign w_unused_bank_idx = ^req_i.tgt_addr[BankIdxWidth-1:0];
  assign w_is_rmw          = (w_amo >= AmoSwap) && (w_amo <= AmoMinu);
  assign w_is_lr           = (w_amo == AmoLR);
  assign w_is_sc           = (w_amo == AmoSC);
  assign w_is_store        = req_i.wen & ~w_is_rmw & ~w_is_lr & ~w_is_sc;
  assign w_sc_ok           = r_res.valid && (r_res.addr == w_req_addr) &&
                             (r_res.ini_addr == req_i.ini_addr) &&
                             (r_res.core_id == req_i.wdata.core_id);

  // Credit check: the unstallable SRAM read always finds a free FIFO slot.
  assign w_used      = (CntW+1)'(w_fifo_count) + (CntW+1)'(r_inflight);
  assign req_ready_o = ~rst_i && (r_state == StIdle) && (w_used < (CntW+1)'(RespDepth));
  assign w_accept    = req_valid_i & req_ready_o;

  // Next state and bank port mux.
  always_comb begin
    w_state_next = r_state;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = w_req_addr;
    mem_wdata_o  = req_i.wdata.data;
    mem_be_o     = req_i.be;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          mem_req_o = ~w_is_sc | w_sc_ok;
          mem_we_o  = w_is_store | (w_is_sc & w_sc_ok);
          if (w_is_rmw) w_state_next = StAmoWb;
        end
      end
      StAmoWb: begin
        mem_req_o    = ~rst_i;
        mem_we_o     = ~rst_i;
        mem_addr_o   = r_wb_addr;
        mem_wdata_o  = amo_alu(r_amo, mem_rdata_i, r_operand);
        mem_be_o     = '1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // A response is owed in the cycle after every accepted non-store request.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_inflight <= 1'b0;
    else       r_inflight <= w_accept & ~w_is_store;
  end

  // Per-request context needed for the response and AMO write-back.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_meta    <= req_i.wdata.meta_id;
      r_core    <= req_i.wdata.core_id;
      r_ini     <= req_i.ini_addr;
      r_amo     <= w_amo;
      r_operand <= req_i.wdata.data;
      r_wb_addr <= w_req_addr;
      r_pend_sc <= w_is_sc;
      r_sc_fail <= ~w_sc_ok;
    end
  end

  // SC responses carry the status flag; everything else carries the bank word.
  always_comb begin
    w_push_data               = '0;
    w_push_data.rdata.meta_id = r_meta;
    w_push_data.rdata.core_id = r_core;
    w_push_data.rdata.amo     = r_amo;
    w_push_data.rdata.data    = r_pend_sc ? DataWidth'(r_sc_fail) : mem_rdata_i;
    w_push_data.ini_addr      = r_ini;
  end

  assign w_push    = r_inflight & ~rst_i;
  assign w_wb_kill = (r_state == StAmoWb) && (r_wb_addr == r_res.addr);

  // Reservation: cleared by SC or writes to the reserved word, LR applied last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res <= '0;
    end else begin
      if (w_accept && w_is_sc) r_res.valid <= 1'b0;
      if (w_accept && w_is_store && (w_req_addr == r_res.addr)) r_res.valid <= 1'b0;
      if (w_wb_kill) r_res.valid <= 1'b0;
      if (w_accept && w_is_lr) begin
        r_res.valid    <= 1'b1;
        r_res.addr     <= w_req_addr;
        r_res.ini_addr <= req_i.ini_addr;
        r_res.core_id  <= req_i.wdata.core_id;
      end
    end
  end

  tcdm_resp_fifo #(
    .Depth (RespDepth)
  ) i_resp_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .o_valid (resp_valid_o),
    .i_ready (resp_ready_i),
    .o_data  (resp_o),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: directed scenarios plus random traffic against a golden memory model.
module tb_tcdm_bank_responder;
  import tcdm_bank_responder_pkg::*;

  localparam int unsigned RespDepth = 2;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  tcdm_slave_req_t  req_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  tcdm_slave_resp_t resp_o;
  logic             mem_req_o;
  logic             mem_we_o;
  bank_addr_t       mem_addr_o;
  data_t            mem_wdata_o;
  strb_t            mem_be_o;
  data_t            mem_rdata_i;

  always #5 clk = ~clk;

  tcdm_bank_responder #(.RespDepth(RespDepth)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_i        (req_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_o       (resp_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  function automatic data_t seed_val(int i);
    return (data_t'(i) * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // SRAM bank: 1-cycle read latency, byte-enabled writes, seeded once during the first reset.
  data_t sram [256];
  data_t rdata_q;
  bit    seeded = 1'b0;
  always @(posedge clk) begin
    if (rst_i && !seeded) begin
      for (int i = 0; i < 256; i++) sram[i] <= seed_val(i);
      seeded <= 1'b1;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        rdata_q <= sram[mem_addr_o];
      end
    end
  end
  assign mem_rdata_i = rdata_q;

  // Golden model state.
  data_t            gmem [256];
  bit               res_valid;
  int               res_addr;
  ini_addr_t        res_ini;
  core_id_t         res_core;
  tcdm_slave_resp_t exp_q [$];

  int               checks = 0;
  int               errors = 0;
  int               n_acc;
  logic             s_ready;
  logic             s_rvalid;
  bit               stall_pend = 1'b0;
  tcdm_slave_resp_t stall_resp;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic tcdm_slave_req_t mk_req(int amo, bit wen, int be, int tgt, data_t d,
                                             int meta, int core, int ini);
    tcdm_slave_req_t r;
    r               = '0;
    r.wdata.amo     = amo_t'(amo);
    r.wdata.data    = d;
    r.wdata.meta_id = meta_id_t'(meta);
    r.wdata.core_id = core_id_t'(core);
    r.wen           = wen;
    r.be            = strb_t'(be);
    r.tgt_addr      = tgt_addr_t'(tgt);
    r.ini_addr      = ini_addr_t'(ini);
    return r;
  endfunction

  function automatic data_t ref_amo(int op, data_t old, data_t opd);
    int so;
    int sp;
    so = old;
    sp = opd;
    case (op)
      1: return opd;
      2: return old + opd;
      3: return old & opd;
      4: return old | opd;
      5: return old ^ opd;
      6: return (so > sp) ? old : opd;
      7: return (old > opd) ? old : opd;
      8: return (so < sp) ? old : opd;
      9: return (old < opd) ? old : opd;
      default: return old;
    endcase
  endfunction

  task automatic write_be(input int a, input tcdm_slave_req_t r);
    for (int b = 0; b < 4; b++)
      if (r.be[b]) gmem[a][8*b +: 8] = r.wdata.data[8*b +: 8];
  endtask

  // Atomic effect of one accepted request on the golden memory and response queue.
  task automatic model_accept(input tcdm_slave_req_t r);
    int               a;
    int               op;
    bit               ok;
    tcdm_slave_resp_t e;
    a  = int'(r.tgt_addr) / NumBanksPerTile;
    op = int'(r.wdata.amo);
    e  = '0;
    e.rdata.meta_id = r.wdata.meta_id;
    e.rdata.core_id = r.wdata.core_id;
    e.rdata.amo     = r.wdata.amo;
    e.ini_addr      = r.ini_addr;
    if (op >= 1 && op <= 9) begin
      e.rdata.data = gmem[a];
      gmem[a] = ref_amo(op, gmem[a], r.wdata.data);
      if (res_valid && res_addr == a) res_valid = 1'b0;
      exp_q.push_back(e);
    end else if (op == 10) begin
      e.rdata.data = gmem[a];
      res_valid = 1'b1; res_addr = a; res_ini = r.ini_addr; res_core = r.wdata.core_id;
      exp_q.push_back(e);
    end else if (op == 11) begin
      ok = res_valid && res_addr == a && res_ini == r.ini_addr && res_core == r.wdata.core_id;
      if (ok) write_be(a, r);
      e.rdata.data = ok ? 32'd0 : 32'd1;
      res_valid = 1'b0;
      exp_q.push_back(e);
    end else if (r.wen) begin
      write_be(a, r);
      if (res_valid && res_addr == a) res_valid = 1'b0;
    end else begin
      e.rdata.data = gmem[a];
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: drive, sample handshakes before the edge, score them.
  task automatic step(input logic v, input tcdm_slave_req_t r, input logic rr);
    tcdm_slave_resp_t e;
    @(negedge clk);
    req_valid_i  = v;
    req_i        = r;
    resp_ready_i = rr;
    #1;
    s_ready  = req_ready_o;
    s_rvalid = resp_valid_o;
    if (stall_pend)
      chk_eq("resp_held", 64'({resp_valid_o, resp_o}), 64'({1'b1, stall_resp}));
    stall_pend = resp_valid_o & ~rr;
    stall_resp = resp_o;
    if (resp_valid_o && rr) begin
      chk_eq("resp_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk_eq("resp", 64'(resp_o), 64'(e));
      end
    end
    if (v && req_ready_o) begin
      model_accept(r);
      n_acc++;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (exp_q.size() != 0 || s_rvalid); i++) step(1'b0, '0, 1'b1);
    chk_eq(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_random(input int n);
    tcdm_slave_req_t r;
    bit              v;
    bit              rr;
    for (int i = 0; i < n; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      r  = mk_req(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)) * NumBanksPerTile + int'($urandom_range(0, 15)),
                  $urandom, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)));
      step(v, r, rr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) gmem[i] = seed_val(i);
    res_valid    = 1'b0;
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_i        = '0;
    resp_ready_i = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_ready", 64'(req_ready_o), 64'(0));
    chk_eq("rst_rvalid", 64'(resp_valid_o), 64'(0));
    chk_eq("rst_mem_req", 64'(mem_req_o), 64'(0));
    chk_eq("rst_mem_we", 64'(mem_we_o), 64'(0));
    @(negedge clk);
    rst_i = 1'b0;
    step(1'b0, '0, 1'b1);
    chk_eq("rst_ready_after", 64'(s_ready), 64'(1));

    // Read after store, 1-cycle latency, echo fields
    step(1'b1, mk_req(0, 1'b1, 15, 'h10, 32'hDEAD_BEEF, 0, 0, 2), 1'b1);
    step(1'b1, mk_req(0, 1'b0, 15, 'h10, 32'h0, 'h5A, 3, 6), 1'b1);
    step(1'b0, '0, 1'b1);
    chk_eq("ld_latency", 64'(s_rvalid), 64'(1));
    chk_eq("ld_data", 64'(resp_o.rdata.data), 64'hDEAD_BEEF);
    chk_eq("ld_meta", 64'(resp_o.rdata.meta_id), 64'h5A);
    chk_eq("ld_ini", 64'(resp_o.ini_addr), 64'd6);

    // Backpressure: only RespDepth loads get in
    n_acc = 0;
    for (int i = 0; i < 4; i++) step(1'b1, mk_req(0, 1'b0, 15, 'h50 + 16 * i, 32'h0, i, 0, 1), 1'b0);
    chk_eq("bp_accepted", 64'(n_acc), 64'(RespDepth));
    chk_eq("bp_ready", 64'(s_ready), 64'(0));
    drain("bp_drained");

    // AMO ADD wraps, ready low for exactly the write-back cycle
    step(1'b1, mk_req(0, 1'b1, 15, 'h90, 32'hFFFF_FFFF, 0, 0, 0), 1'b1);
    step(1'b1, mk_req(2, 1'b0, 15, 'h90, 32'd2, 7, 2, 3), 1'b1);
    step(1'b0, '0, 1'b1);
    chk_eq("amo_ready_low", 64'(s_ready), 64'(0));
    chk_eq("amo_old", 64'(resp_o.rdata.data), 64'hFFFF_FFFF);
    step(1'b0, '0, 1'b1);
    chk_eq("amo_ready_back", 64'(s_ready), 64'(1));
    chk_eq("amo_add_mem", 64'(sram[9]), 64'h1);

    // AMO MAX is signed
    step(1'b1, mk_req(0, 1'b1, 15, 'hA0, 32'h8000_0000, 0, 0, 0), 1'b1);
    step(1'b1, mk_req(6, 1'b0, 15, 'hA0, 32'd5, 1, 0, 0), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk_eq("amo_max_mem", 64'(sram[10]), 64'd5);

    // LR/SC success then a second SC fails
    step(1'b1, mk_req(10, 1'b0, 15, 'h20, 32'h0, 1, 1, 4), 1'b1);
    step(1'b1, mk_req(11, 1'b1, 15, 'h20, 32'h1234_5678, 2, 1, 4), 1'b1);
    step(1'b0, '0, 1'b1);
    chk_eq("sc_ok_data", 64'(resp_o.rdata.data), 64'd0);
    chk_eq("sc_ok_mem", 64'(sram[2]), 64'h1234_5678);
    step(1'b1, mk_req(11, 1'b1, 15, 'h20, 32'h9ABC_DEF0, 3, 1, 4), 1'b1);
    step(1'b0, '0, 1'b1);
    chk_eq("sc_again_data", 64'(resp_o.rdata.data), 64'd1);
    chk_eq("sc_again_mem", 64'(sram[2]), 64'h1234_5678);

    // Reservation killed by a foreign store
    step(1'b1, mk_req(10, 1'b0, 15, 'h20, 32'h0, 4, 0, 1), 1'b1);
    step(1'b1, mk_req(0, 1'b1, 15, 'h20, 32'hCAFE_F00D, 5, 2, 7), 1'b1);
    step(1'b1, mk_req(11, 1'b1, 15, 'h20, 32'hBAD0_BAD0, 6, 0, 1), 1'b1);
    step(1'b0, '0, 1'b1);
    chk_eq("kill_sc_data", 64'(resp_o.rdata.data), 64'd1);
    chk_eq("kill_mem", 64'(sram[2]), 64'hCAFE_F00D);
    drain("dir_drained");

    // Reset during the AMO write-back cycle
    step(1'b1, mk_req(0, 1'b1, 15, 'h30, 32'h1122_3344, 0, 0, 0), 1'b1);
    step(1'b1, mk_req(1, 1'b0, 15, 'h30, 32'h5555_5555, 9, 0, 0), 1'b1);
    @(negedge clk);
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    #1;
    chk_eq("rstamo_we", 64'(mem_we_o), 64'(0));
    chk_eq("rstamo_req", 64'(mem_req_o), 64'(0));
    chk_eq("rstamo_rvalid", 64'(resp_valid_o), 64'(0));
    @(negedge clk);
    #1;
    chk_eq("rstamo_mem", 64'(sram[3]), 64'h1122_3344);
    chk_eq("rstamo_rvalid2", 64'(resp_valid_o), 64'(0));
    gmem[3] = 32'h1122_3344;
    exp_q.delete();
    res_valid  = 1'b0;
    stall_pend = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    step(1'b0, '0, 1'b1);
    chk_eq("rstamo_ready", 64'(s_ready), 64'(1));
    chk_eq("rstamo_no_resp", 64'(s_rvalid), 64'(0));

    // Random traffic
    run_random(1500);
    drain("rand_drained");
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 256; i++) chk_eq($sformatf("mem[%0d]", i), 64'(sram[i]), 64'(gmem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
